// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: round-robin sharing of one SPI-mode SD block reader between two clients,
// issuing one block read per grant and streaming its bytes to the owner with valid/ready.
module sd_block_arbiter #(
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT     = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    output logic [1:0]  grant,
    output logic [7:0]  byte_data,
    output logic [1:0]  byte_valid,
    input  logic [1:0]  byte_ready,
    output logic        byte_last,
    output logic [1:0]  done,
    output logic        err,
    input  logic        sd_busy,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    input  logic [7:0]  sd_dout,
    input  logic        sd_dout_avail,
    output logic        sd_dout_taken,
    input  logic        sd_error
);
    localparam int CW = $clog2(BLOCK_BYTES) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, STREAM, FINISH} state_t;
    state_t state, state_n;
    logic [1:0] rr_ptr, pick;
    logic [CW-1:0] byte_cnt;
    logic [TW-1:0] timeout_cnt;
    logic held, active, capture, accept, last_acc, timed_out, fail;
    assign held   = |byte_valid;
    assign active = state == WAIT_START || state == STREAM;
    // rr_ptr holds the one-hot grant of the last served client; zero means nobody yet, so client 0 wins a tie
    assign pick   = req == 2'b11 ? (rr_ptr[0] ? 2'b10 : 2'b01) : req;
    always_comb begin
        fail      = state != IDLE && state != FINISH && sd_error;
        capture   = active && sd_dout_avail && !held && !sd_dout_taken && !sd_error;
        accept    = active && |(byte_valid & byte_ready);
        last_acc  = accept && byte_last;
        timed_out = active && !held && !capture && timeout_cnt == TW'(TIMEOUT - 1);
        state_n   = state;
        if (state == FINISH) state_n = IDLE;
        else if (fail || timed_out || last_acc) state_n = FINISH;
        else if (state == IDLE && !sd_busy && |req) state_n = ISSUE;
        else if (state == ISSUE) state_n = WAIT_START;
        else if (state == WAIT_START && capture) state_n = STREAM;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= 2'b00;
            rr_ptr        <= 2'b00;
            sd_addr       <= 32'd0;
            sd_rd         <= 1'b0;
            sd_dout_taken <= 1'b0;
            byte_data     <= 8'd0;
            byte_valid    <= 2'b00;
            byte_last     <= 1'b0;
            byte_cnt      <= '0;
            timeout_cnt   <= '0;
            done          <= 2'b00;
            err           <= 1'b0;
        end else begin
            state         <= state_n;
            sd_rd         <= state == IDLE && state_n == ISSUE;
            sd_dout_taken <= accept;
            done          <= state_n == FINISH ? grant : 2'b00;
            err           <= state_n == FINISH && (fail || timed_out);
            if (state == IDLE && state_n == ISSUE) begin
                grant   <= pick;
                sd_addr <= pick[1] ? addr1 : addr0;
            end
            if (state == FINISH) begin
                grant  <= 2'b00;
                rr_ptr <= grant;
            end
            if (state == ISSUE) begin
                byte_cnt    <= '0;
                timeout_cnt <= '0;
            end else if (capture) begin
                byte_data   <= sd_dout;
                byte_valid  <= grant;
                byte_last   <= byte_cnt == CW'(BLOCK_BYTES - 1);
                timeout_cnt <= '0;
            end else if (active && !held) begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end
            if (accept) begin
                byte_valid <= 2'b00;
                byte_last  <= 1'b0;
                byte_cnt   <= byte_cnt + CW'(1);
            end
            if (state_n == FINISH) begin
                byte_valid <= 2'b00;
                byte_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb_sd_block_arbiter: block-level scenarios against a cycle-stepped SD controller / client model
// and a reference of the round-robin and byte-stream rules.
module tb_sd_block_arbiter;
    localparam int BB = 512, TO = 64;
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] req = 2'b00, byte_ready = 2'b00;
    logic [31:0] addr0 = 32'd0, addr1 = 32'd0, sd_addr;
    logic [1:0] grant, byte_valid, done;
    logic [7:0] byte_data, sd_dout = 8'd0;
    logic byte_last, err, sd_rd, sd_dout_taken;
    logic sd_busy = 1'b0, sd_dout_avail = 1'b0, sd_error = 1'b0;
    int checks = 0, failures = 0;

    typedef struct {
        bit rst; logic [1:0] req; logic [31:0] a0; logic [31:0] a1; logic [7:0] seed;
        int err_at; int hold_at; bit no_avail; int rp; int gm; int busy;
        logic [1:0] exp_done; bit exp_err; int exp_n;
    } blk_t;

    int cyc = 0, sd_idx, sd_gap, err_at, hold_at, hold_cnt, n_rx, n_rd, ready_pct, gap_max;
    int bad_data, rd_cyc, err_cyc, last_served = -1;
    bit sd_on = 0, no_avail, hold_bad, proto_bad;
    logic [7:0] seed, held_byte;
    logic [31:0] rd_addr;
    logic [1:0] g_seen;

    always #5 clk = ~clk;

    sd_block_arbiter #(.BLOCK_BYTES(BB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1), .grant(grant),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last),
        .done(done), .err(err), .sd_busy(sd_busy), .sd_rd(sd_rd), .sd_addr(sd_addr),
        .sd_dout(sd_dout), .sd_dout_avail(sd_dout_avail), .sd_dout_taken(sd_dout_taken), .sd_error(sd_error)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] ref_pick(input logic [1:0] r);
        return r == 2'b11 ? (last_served == 0 ? 2'b10 : 2'b01) : r;
    endfunction

    // One clock: observe DUT after the edge, advance controller and client models, drive new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sd_error = 1'b0;
        if (g_seen == 2'b00 && grant != 2'b00) g_seen = grant;
        if ((byte_valid & ~grant) != 2'b00 || (done & ~grant) != 2'b00 || byte_valid == 2'b11 || (err && done == 2'b00))
            proto_bad = 1;
        if (sd_rd) begin
            n_rd++; rd_addr = sd_addr; rd_cyc = cyc;
            sd_on = 1; sd_idx = 0; sd_gap = $urandom_range(gap_max, 0);
        end
        if (sd_dout_taken) begin
            sd_dout_avail = 1'b0; sd_idx++; sd_gap = $urandom_range(gap_max, 0);
        end else if (sd_on && !no_avail && !sd_dout_avail && sd_idx < BB) begin
            if (sd_idx == err_at) begin
                sd_error = 1'b1; sd_on = 0; err_cyc = cyc;
            end else if (sd_gap == 0) begin
                sd_dout_avail = 1'b1; sd_dout = seed + 8'(sd_idx);
            end else sd_gap--;
        end
        if (done != 2'b00) begin
            sd_on = 0; sd_dout_avail = 1'b0;
        end
        if (hold_at >= 0 && n_rx == hold_at && byte_valid != 2'b00 && hold_cnt < 100) begin
            if (hold_cnt == 0) held_byte = byte_data;
            else if (byte_valid != grant || byte_data != held_byte || sd_dout_taken || done != 2'b00) hold_bad = 1;
            hold_cnt++;
            byte_ready = 2'b00;
        end else byte_ready = ($urandom_range(99, 0) < ready_pct) ? 2'b11 : 2'b00;
        if ((byte_valid & byte_ready) != 2'b00) begin
            if (byte_data !== seed + 8'(n_rx) || byte_last !== (n_rx == BB - 1)) bad_data++;
            n_rx++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 2'b00; sd_on = 0; sd_dout_avail = 1'b0; sd_error = 1'b0; last_served = -1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {grant, byte_valid, byte_last, done, err, sd_rd, sd_dout_taken, sd_addr, byte_data}, 0);
        reset = 1'b0;
    endtask

    task automatic start(input blk_t b);
        if (b.rst) do_reset();
        req = b.req; addr0 = b.a0; addr1 = b.a1; seed = b.seed;
        err_at = b.err_at; hold_at = b.hold_at; no_avail = b.no_avail; ready_pct = b.rp; gap_max = b.gm;
        n_rx = 0; n_rd = 0; hold_cnt = 0; hold_bad = 0; bad_data = 0; proto_bad = 0; g_seen = 2'b00;
        rd_cyc = 0; err_cyc = 0;
    endtask

    task automatic run_block(input blk_t b);
        int t = 0;
        start(b);
        sd_busy = b.busy > 0;
        for (int i = 0; i < b.busy; i++) tick();
        if (b.busy > 0) check("busy_hold", g_seen, 2'b00);
        sd_busy = 1'b0;
        while (done == 2'b00 && t < 20000) begin tick(); t++; end
        check("grant", g_seen, b.exp_done);
        check("done", done, b.exp_done);
        check("err", err, b.exp_err);
        check("byte_count", n_rx, b.exp_n);
        check("byte_data", bad_data, 0);
        check("sd_rd_pulses", n_rd, 1);
        check("sd_addr", rd_addr, b.exp_done[1] ? b.a1 : b.a0);
        check("protocol", proto_bad, 0);
        if (b.hold_at >= 0) check("backpressure", {hold_bad, hold_cnt == 100}, 2'b01);
        if (b.no_avail) check("timeout_latency", cyc - rd_cyc, TO + 1);
        if (b.err_at >= 0) check("error_latency", (cyc - err_cyc) <= 2, 1);
        last_served = b.exp_done[1] ? 1 : 0;
        tick();
        check("after_finish", {grant, done, err}, 0);
    endtask

    initial begin
        blk_t tbl[8];
        blk_t r;
        int t;
        tbl[0] = '{0, 2'b01, 32'h10,  32'h0,  8'h00, -1,  -1, 0, 100, 0, 0, 2'b01, 0, BB};
        tbl[1] = '{1, 2'b11, 32'h20,  32'h30, 8'h5A, -1,  -1, 0, 80,  1, 0, 2'b01, 0, BB};
        tbl[2] = '{0, 2'b11, 32'h20,  32'h30, 8'h11, -1,  -1, 0, 80,  1, 2, 2'b10, 0, BB};
        tbl[3] = '{0, 2'b11, 32'h20,  32'h30, 8'h22, -1,  -1, 0, 100, 2, 0, 2'b01, 0, BB};
        tbl[4] = '{0, 2'b01, 32'h44,  32'h0,  8'h33, -1,  37, 0, 100, 1, 0, 2'b01, 0, BB};
        tbl[5] = '{0, 2'b10, 32'h0,   32'h55, 8'h44, 200, -1, 0, 100, 1, 0, 2'b10, 1, 200};
        tbl[6] = '{0, 2'b01, 32'h66,  32'h0,  8'h55, -1,  -1, 0, 100, 0, 0, 2'b01, 0, BB};
        tbl[7] = '{0, 2'b10, 32'h0,   32'h77, 8'h66, -1,  -1, 1, 100, 0, 0, 2'b10, 1, 0};
        do_reset();
        for (int i = 0; i < 8; i++) run_block(tbl[i]);

        // reset in the middle of a block, then a clean restart
        start('{0, 2'b01, 32'h99, 32'h0, 8'h00, -1, -1, 0, 100, 0, 0, 2'b01, 0, BB});
        t = 0;
        while (n_rx < 300 && t < 20000) begin tick(); t++; end
        check("reached_byte_300", n_rx, 300);
        reset = 1'b1;
        #1;
        check("reset_async", {grant, byte_valid, byte_last, done, err, sd_rd, sd_dout_taken, sd_addr}, 0);
        do_reset();
        run_block('{0, 2'b01, 32'hABC, 32'h0, 8'h07, -1, -1, 0, 100, 1, 0, 2'b01, 0, BB});

        for (int i = 0; i < 5; i++) begin
            r.rst = 0;
            r.req = 2'($urandom_range(3, 1));
            r.a0 = $urandom; r.a1 = $urandom; r.seed = 8'($urandom);
            r.err_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(BB - 1, 0)) : -1;
            r.hold_at = -1; r.no_avail = 0;
            r.rp = $urandom_range(100, 50); r.gm = $urandom_range(3, 0); r.busy = $urandom_range(3, 0);
            r.exp_done = ref_pick(r.req);
            r.exp_err = r.err_at >= 0;
            r.exp_n = r.err_at >= 0 ? r.err_at : BB;
            run_block(r);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
